// File: rtl/fetch_inst_buffer_if.sv
// fetch_inst_buffer_if: the fetch-side and backend-side handshake of the
// fetch instruction buffer, bundled together.
//   i_squash_vld  backend squash, flushes the buffer
//   i_inst_vld    per-lane fetch valids (any pattern, holes allowed)
//   i_inst        fetch entries, lane 0 first in program order
//   o_fetch_ready buffer can accept a full fetch group
//   o_inst_vld    backend valids, always a prefix
//   o_inst        oldest entries, lane 0 oldest
//   i_stall       backend stall; when low all presented lanes are consumed
// slave: the buffer side. master: the fetch unit / backend environment.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

interface fetch_inst_buffer_if #(
  parameter int unsigned FETCH_WIDTH = `FETCH_WIDTH,
  parameter int unsigned ENTRY_W     = 32
);
  logic                                  i_squash_vld;
  logic [FETCH_WIDTH-1:0]                i_inst_vld;
  logic [FETCH_WIDTH-1:0][ENTRY_W-1:0]   i_inst;
  logic                                  o_fetch_ready;
  logic [FETCH_WIDTH-1:0]                o_inst_vld;
  logic [FETCH_WIDTH-1:0][ENTRY_W-1:0]   o_inst;
  logic                                  i_stall;

  modport slave (
    input  i_squash_vld, i_inst_vld, i_inst, i_stall,
    output o_fetch_ready, o_inst_vld, o_inst
  );

  modport master (
    output i_squash_vld, i_inst_vld, i_inst, i_stall,
    input  o_fetch_ready, o_inst_vld, o_inst
  );
endinterface

// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer: decoupling FIFO between fetch and the backend.
// Accepts up to FETCH_WIDTH entries per cycle (holes compacted in program
// order) and presents the oldest up to FETCH_WIDTH entries to the backend.
//   clk  rising-edge clock
//   rst  synchronous, active-low reset
//   bus  fetch_inst_buffer_if.slave (fetch and backend handshakes)
// DEPTH must be a power of two and at least 2*FETCH_WIDTH.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

module fetch_inst_buffer #(
  parameter int unsigned FETCH_WIDTH = `FETCH_WIDTH,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ENTRY_W     = 32
) (
  input logic               clk,
  input logic               rst,
  fetch_inst_buffer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W:0] ptr_t;   // index plus wrap bit

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  ptr_t head_q, head_d, tail_q, tail_d, count_q, count_d;
  ptr_t enq_n, deq_n, enq_amt, deq_amt;
  logic fetch_ready, enq_fire, deq_fire;
  logic [PTR_W-1:0] widx, ridx;
  logic [PTR_W+1:0] count_wide;

  always_comb begin
    // Ready looks only at the registered count, never at this cycle's dequeue.
    fetch_ready = rst && (count_q <= ptr_t'(DEPTH - FETCH_WIDTH));
    enq_fire    = fetch_ready && (|bus.i_inst_vld) && !bus.i_squash_vld;
    deq_n       = (count_q < ptr_t'(FETCH_WIDTH)) ? count_q : ptr_t'(FETCH_WIDTH);
    deq_fire    = !bus.i_stall && !bus.i_squash_vld;

    // Compaction: each valid lane goes to tail + (number of valid lanes below it).
    mem_d = mem_q;
    enq_n = '0;
    widx  = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (bus.i_inst_vld[i]) begin
        widx = tail_q[PTR_W-1:0] + enq_n[PTR_W-1:0];
        if (enq_fire) mem_d[widx] = bus.i_inst[i];
        enq_n = enq_n + ptr_t'(1);
      end
    end

    enq_amt    = enq_fire ? enq_n : '0;
    deq_amt    = deq_fire ? deq_n : '0;
    count_wide = {1'b0, count_q} + {1'b0, enq_amt} - {1'b0, deq_amt};

    if (bus.i_squash_vld) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointer width is log2(DEPTH)+1, so plain addition wraps and toggles the wrap bit.
      head_d  = head_q + deq_amt;
      tail_d  = tail_q + enq_amt;
      count_d = count_q + enq_amt - deq_amt;
    end
  end

  always_comb begin
    bus.o_fetch_ready = fetch_ready;
    bus.o_inst_vld    = '0;
    bus.o_inst        = '0;
    ridx              = '0;
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      ridx          = head_q[PTR_W-1:0] + PTR_W'(k);
      bus.o_inst[k] = mem_q[ridx];
      bus.o_inst_vld[k] = rst && (ptr_t'(k) < deq_n);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (!bus.i_squash_vld) begin
        assert ({1'b0, deq_amt} <= {1'b0, count_q} + {1'b0, enq_amt});
        assert (count_wide <= (PTR_W+2)'(DEPTH));
      end
    end
  end
endmodule

// File: tb/tb_fetch_inst_buffer.sv
module tb_fetch_inst_buffer;
  localparam int FW    = 4;
  localparam int DEPTH = 16;
  localparam int EW    = 16;

  typedef logic [FW-1:0][EW-1:0] grp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_inst_buffer_if #(.FETCH_WIDTH(FW), .ENTRY_W(EW)) bif ();

  fetch_inst_buffer #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .ENTRY_W(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the buffer is just an ordered queue of entries.
  logic [EW-1:0] mq[$];

  typedef struct {
    logic          r, sq, st;
    logic [FW-1:0] vld;
    grp_t          d;
    logic          e_rdy;
    logic [FW-1:0] e_vld;
    grp_t          e_d;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic grp_t grp(input logic [EW-1:0] base);
    grp_t r;
    for (int i = 0; i < FW; i++) r[i] = base + EW'(i);
    return r;
  endfunction

  task automatic drive(input logic r, input logic sq, input logic st,
                       input logic [FW-1:0] vld, input grp_t d);
    rst              = r;
    bif.i_squash_vld = sq;
    bif.i_stall      = st;
    bif.i_inst_vld   = vld;
    bif.i_inst       = d;
  endtask

  task automatic model_check();
    int n;
    logic [FW-1:0] ev;
    n  = (mq.size() < FW) ? mq.size() : FW;
    if (!rst) n = 0;
    ev = '0;
    for (int i = 0; i < n; i++) ev[i] = 1'b1;
    chk("model_ready", 32'(bif.o_fetch_ready), 32'(rst && (mq.size() <= DEPTH - FW)));
    chk("model_vld", 32'(bif.o_inst_vld), 32'(ev));
    for (int k = 0; k < n; k++) chk("model_data", 32'(bif.o_inst[k]), 32'(mq[k]));
  endtask

  task automatic model_update();
    bit rdy;
    int n;
    rdy = rst && (mq.size() <= DEPTH - FW);
    if (!rst || bif.i_squash_vld) begin
      mq.delete();
    end else begin
      if (!bif.i_stall) begin
        n = (mq.size() < FW) ? mq.size() : FW;
        repeat (n) void'(mq.pop_front());
      end
      if (rdy)
        for (int i = 0; i < FW; i++)
          if (bif.i_inst_vld[i]) mq.push_back(bif.i_inst[i]);
    end
  endtask

  task automatic finish_cycle();
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cycle();
  endtask

  initial begin
    // Table: inputs applied this cycle, outputs expected this cycle (before the edge).
    tv[0] = '{1'b0, 1'b0, 1'b0, 4'b1111, grp(16'h0F00), 1'b0, 4'b0000, '0};
    tv[1] = '{1'b0, 1'b0, 1'b0, 4'b1111, grp(16'h0F00), 1'b0, 4'b0000, '0};
    tv[2] = '{1'b0, 1'b0, 1'b0, 4'b1111, grp(16'h0F00), 1'b0, 4'b0000, '0};
    tv[3] = '{1'b1, 1'b1, 1'b0, 4'b1111, grp(16'h0E00), 1'b1, 4'b0000, '0};
    tv[4] = '{1'b1, 1'b0, 1'b1, 4'b1111, grp(16'h00A0), 1'b1, 4'b0000, '0};
    tv[5] = '{1'b1, 1'b0, 1'b0, 4'b0000, '0,            1'b1, 4'b1111, grp(16'h00A0)};
    tv[6] = '{1'b1, 1'b0, 1'b0, 4'b1010, {16'h00B3, 16'h0bad, 16'h00B1, 16'h0bad},
              1'b1, 4'b0000, '0};
    tv[7] = '{1'b1, 1'b0, 1'b1, 4'b0000, '0, 1'b1, 4'b0011, {16'h0, 16'h0, 16'h00B3, 16'h00B1}};
    tv[8] = '{1'b1, 1'b0, 1'b0, 4'b0000, '0, 1'b1, 4'b0011, {16'h0, 16'h0, 16'h00B3, 16'h00B1}};
    tv[9] = '{1'b1, 1'b0, 1'b0, 4'b0000, '0, 1'b1, 4'b0000, '0};

    for (int v = 0; v < 10; v++) begin
      drive(tv[v].r, tv[v].sq, tv[v].st, tv[v].vld, tv[v].d);
      @(negedge clk);
      chk("tbl_ready", 32'(bif.o_fetch_ready), 32'(tv[v].e_rdy));
      chk("tbl_vld", 32'(bif.o_inst_vld), 32'(tv[v].e_vld));
      for (int k = 0; k < FW; k++)
        if (tv[v].e_vld[k]) chk("tbl_data", 32'(bif.o_inst[k]), 32'(tv[v].e_d[k]));
      finish_cycle();
    end

    // Full and stall: four groups fill the buffer, a fifth is refused.
    for (int g = 0; g < 4; g++) begin
      drive(1'b1, 1'b0, 1'b1, 4'b1111, grp(16'h0C00 + 16'(4 * g)));
      cycle();
    end
    drive(1'b1, 1'b0, 1'b1, 4'b1111, grp(16'hDEA0));
    @(negedge clk);
    chk("full_ready", 32'(bif.o_fetch_ready), 32'd0);
    chk("full_vld", 32'(bif.o_inst_vld), 32'hF);
    finish_cycle();
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 1'b0, 1'b0, 4'b0000, '0);
      @(negedge clk);
      chk("drain_vld", 32'(bif.o_inst_vld), 32'hF);
      chk("drain_lane0", 32'(bif.o_inst[0]), 32'(16'h0C00 + 16'(4 * j)));
      chk("drain_lane3", 32'(bif.o_inst[3]), 32'(16'h0C03 + 16'(4 * j)));
      finish_cycle();
    end
    cycle();

    // Ready boundary: 12 still ready, 13 not ready even with a dequeue.
    for (int g = 0; g < 3; g++) begin
      drive(1'b1, 1'b0, 1'b1, 4'b1111, grp(16'h1000 + 16'(4 * g)));
      cycle();
    end
    drive(1'b1, 1'b0, 1'b1, 4'b0001, grp(16'h1100));
    @(negedge clk);
    chk("ready_at_12", 32'(bif.o_fetch_ready), 32'd1);
    finish_cycle();
    drive(1'b1, 1'b0, 1'b0, 4'b1111, grp(16'hEE00));
    @(negedge clk);
    chk("ready_at_13", 32'(bif.o_fetch_ready), 32'd0);
    finish_cycle();
    drive(1'b1, 1'b0, 1'b0, 4'b0000, '0);
    @(negedge clk);
    chk("ready_at_9", 32'(bif.o_fetch_ready), 32'd1);
    finish_cycle();
    repeat (3) cycle();

    // Reset mid-operation with 9 entries and stall asserted.
    drive(1'b1, 1'b0, 1'b1, 4'b1111, grp(16'h2000)); cycle();
    drive(1'b1, 1'b0, 1'b1, 4'b1111, grp(16'h2004)); cycle();
    drive(1'b1, 1'b0, 1'b1, 4'b0001, grp(16'h2008)); cycle();
    drive(1'b0, 1'b0, 1'b1, 4'b0000, '0);            cycle();
    drive(1'b1, 1'b0, 1'b1, 4'b1111, grp(16'h5000));
    @(negedge clk);
    chk("rstmid_vld", 32'(bif.o_inst_vld), 32'd0);
    chk("rstmid_ready", 32'(bif.o_fetch_ready), 32'd1);
    finish_cycle();
    drive(1'b1, 1'b0, 1'b0, 4'b0000, '0);
    @(negedge clk);
    chk("rstmid_new_vld", 32'(bif.o_inst_vld), 32'hF);
    for (int k = 0; k < FW; k++)
      chk("rstmid_new_data", 32'(bif.o_inst[k]), 32'(16'h5000 + 16'(k)));
    finish_cycle();

    // Wrap: from reset, load 14, drain 14, then a group lands in slots 14,15,0,1.
    drive(1'b0, 1'b0, 1'b0, 4'b0000, '0); cycle();
    for (int g = 0; g < 3; g++) begin
      drive(1'b1, 1'b0, 1'b1, 4'b1111, grp(16'h3000 + 16'(4 * g)));
      cycle();
    end
    drive(1'b1, 1'b0, 1'b1, 4'b0011, grp(16'h3100)); cycle();
    drive(1'b1, 1'b0, 1'b0, 4'b0000, '0);
    repeat (4) cycle();
    drive(1'b1, 1'b0, 1'b1, 4'b1111, grp(16'h7000)); cycle();
    drive(1'b1, 1'b0, 1'b1, 4'b0000, '0);
    @(negedge clk);
    chk("wrap_vld", 32'(bif.o_inst_vld), 32'hF);
    for (int k = 0; k < FW; k++)
      chk("wrap_data", 32'(bif.o_inst[k]), 32'(16'h7000 + 16'(k)));
    chk("wrap_head", 32'(dut.head_q), 32'h0E);
    chk("wrap_tail", 32'(dut.tail_q), 32'h12);
    chk("wrap_slot15", 32'(dut.mem_q[15]), 32'h7001);
    chk("wrap_slot0", 32'(dut.mem_q[0]), 32'h7002);
    finish_cycle();
    drive(1'b1, 1'b0, 1'b0, 4'b0000, '0); cycle();

    // Squash priority: count 6, enqueue and squash together.
    drive(1'b1, 1'b0, 1'b1, 4'b1111, grp(16'h4000)); cycle();
    drive(1'b1, 1'b0, 1'b1, 4'b0011, grp(16'h4004)); cycle();
    drive(1'b1, 1'b1, 1'b0, 4'b1111, grp(16'hDD00)); cycle();
    drive(1'b1, 1'b0, 1'b0, 4'b0000, '0);
    @(negedge clk);
    chk("squash_vld", 32'(bif.o_inst_vld), 32'd0);
    chk("squash_ready", 32'(bif.o_fetch_ready), 32'd1);
    finish_cycle();
    cycle();

    // Randomized traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 9) < 6),
            FW'($urandom),
            {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
